// File: rtl/parallel2seq.sv
// Serializer: splits one IN_WIDTH word into NUM OUT_WIDTH beats, least-significant slice first.
// A one-word holding buffer lets the next word reload the shifter on the last beat without a bubble.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef IF_WIDTH
`define IF_WIDTH 1
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 4
`endif

module parallel2seq #(
    parameter int IN_WIDTH  = `DATA_WIDTH * `IF_WIDTH * `KERNEL_WIDTH,
    parameter int OUT_WIDTH = `DATA_WIDTH * `IF_WIDTH,
    parameter int NUM       = IN_WIDTH / OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  parallel_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_serial,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy
);

    localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0] LAST_N = CW'(NUM - 1);

    logic [IN_WIDTH-1:0] r_buf;
    logic                r_buf_full;
    logic [IN_WIDTH-1:0] r_sr;
    logic                r_active;
    logic [CW-1:0]       r_n;

    logic                w_accept;
    logic                w_take;
    logic                w_at_last;

    assign w_accept  = in_valid && !r_buf_full;
    assign w_take    = r_active && out_ready;
    assign w_at_last = (r_n == LAST_N);

    // Holding buffer, shifter, beat counter and their flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_sr       <= '0;
            r_active   <= 1'b0;
            r_n        <= '0;
        end else begin
            // Accept and drain of the buffer are mutually exclusive: draining needs buf_full, accepting needs !buf_full.
            if (w_accept) begin
                r_buf      <= parallel_in;
                r_buf_full <= 1'b1;
            end else if ((w_take && w_at_last && r_buf_full) || (!r_active && r_buf_full)) begin
                r_buf_full <= 1'b0;
            end else begin
                r_buf_full <= r_buf_full;
            end

            if (w_take) begin
                if (!w_at_last) begin
                    r_sr <= r_sr >> OUT_WIDTH;
                    r_n  <= r_n + CW'(1);
                end else if (r_buf_full) begin
                    r_sr <= r_buf;
                    r_n  <= '0;
                end else begin
                    r_active <= 1'b0;
                    r_n      <= '0;
                end
            end else if (!r_active && r_buf_full) begin
                r_sr     <= r_buf;
                r_active <= 1'b1;
                r_n      <= '0;
            end else begin
                r_sr <= r_sr;
                r_n  <= r_n;
            end
        end
    end

    assign in_ready   = !r_buf_full;
    assign out_valid  = r_active;
    assign out_serial = r_sr[OUT_WIDTH-1:0];
    assign out_first  = r_active && (r_n == '0);
    assign out_last   = r_active && w_at_last;
    assign busy       = r_active || r_buf_full;

endmodule

// File: tb/tb_parallel2seq.sv
// Scoreboard bench for parallel2seq (32-bit words, 8-bit beats, 4 beats per word).
module tb_parallel2seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] parallel_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_serial;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int beats = 0;
    int cyc = 0;
    logic [9:0] exp_q[$];
    logic contig_chk = 1'b0;
    logic have_prev = 1'b0;
    int prev_cyc = 0;

    parallel2seq #(.IN_WIDTH(32), .OUT_WIDTH(8), .NUM(4)) dut (
        .clk(clk), .reset(reset), .parallel_in(parallel_in), .in_valid(in_valid),
        .in_ready(in_ready), .out_serial(out_serial), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({(k == 0), (k == 3), w[8*k +: 8]});
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: every handshaken beat is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h expected=none t=%0t", out_serial, $time);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("beat_data", {24'h0, out_serial}, {24'h0, e[7:0]});
                check("beat_first", {31'h0, out_first}, {31'h0, e[9]});
                check("beat_last", {31'h0, out_last}, {31'h0, e[8]});
            end
            if (contig_chk) begin
                if (have_prev) check("beat_contiguous", cyc - prev_cyc, 1);
                prev_cyc = cyc;
                have_prev = 1'b1;
            end
            beats++;
        end
    end

    initial begin
        int base;
        int k;
        int accepts;
        logic [31:0] words [3];
        logic [6:0] pat;
        logic [7:0] prev;
        logic [31:0] v;

        reset = 1'b1;
        parallel_in = 32'h0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        // 1: reset state
        #2;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_serial", {24'h0, out_serial}, 32'h0);
        check("rst_out_first", {31'h0, out_first}, 32'h0);
        check("rst_out_last", {31'h0, out_last}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // 2: single word, latency and framing
        out_ready = 1'b1;
        in_valid = 1'b1;
        parallel_in = 32'h44332211;
        push_word(32'h44332211);
        tick();
        in_valid = 1'b0;
        check("t2_valid_after_accept", {31'h0, out_valid}, 32'h0);
        check("t2_busy_after_accept", {31'h0, busy}, 32'h1);
        check("t2_in_ready_after_accept", {31'h0, in_ready}, 32'h0);
        tick();
        check("t2_first_beat_valid", {31'h0, out_valid}, 32'h1);
        check("t2_first_beat_data", {24'h0, out_serial}, 32'h11);
        check("t2_first_flag", {31'h0, out_first}, 32'h1);
        tick(); tick(); tick();
        check("t2_last_beat_data", {24'h0, out_serial}, 32'h44);
        check("t2_last_flag", {31'h0, out_last}, 32'h1);
        tick();
        check("t2_valid_after_last", {31'h0, out_valid}, 32'h0);
        check("t2_busy_after_last", {31'h0, busy}, 32'h0);

        // 3: three back-to-back words, no bubble
        words[0] = 32'h03020100;
        words[1] = 32'h13121110;
        words[2] = 32'h23222120;
        base = beats;
        have_prev = 1'b0;
        contig_chk = 1'b1;
        for (int w = 0; w < 3; w++) begin
            parallel_in = words[w];
            in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 20) begin
                tick();
                k++;
            end
            check("t3_accept_wait", {31'h0, in_ready}, 32'h1);
            if (w == 2) check("t3_w2_after_w0_last", {31'h0, (beats - base) >= 4}, 32'h1);
            push_word(words[w]);
            tick();
            if (w == 1) check("t3_in_ready_low_buf_full", {31'h0, in_ready}, 32'h0);
        end
        in_valid = 1'b0;
        drain(40);
        contig_chk = 1'b0;
        check("t3_beats_total", beats - base, 12);
        check("t3_idle_after", {31'h0, out_valid}, 32'h0);

        // 4: back-pressure pattern 1,0,0,1,1,0,1
        out_ready = 1'b0;
        in_valid = 1'b1;
        parallel_in = 32'hDDCCBBAA;
        push_word(32'hDDCCBBAA);
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_loaded_data", {24'h0, out_serial}, 32'hAA);
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            prev = out_serial;
            tick();
            if (!pat[i]) begin
                check("t4_stall_hold", {24'h0, out_serial}, {24'h0, prev});
                check("t4_stall_valid", {31'h0, out_valid}, 32'h1);
            end
        end
        check("t4_done_valid", {31'h0, out_valid}, 32'h0);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: async reset mid-word with a pending buffered word
        out_ready = 1'b1;
        in_valid = 1'b1;
        parallel_in = 32'h44332211;
        exp_q.push_back({1'b1, 1'b0, 8'h11});
        exp_q.push_back({1'b0, 1'b0, 8'h22});
        tick();
        parallel_in = 32'h88776655;
        tick();
        tick();
        in_valid = 1'b0;
        check("t5_buf_pending", {31'h0, in_ready}, 32'h0);
        tick();
        check("t5_beat2_shown", {24'h0, out_serial}, 32'h33);
        base = beats;
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", {31'h0, out_valid}, 32'h0);
        check("t5_async_busy", {31'h0, busy}, 32'h0);
        check("t5_async_in_ready", {31'h0, in_ready}, 32'h1);
        check("t5_async_serial", {24'h0, out_serial}, 32'h0);
        check("t5_queue_consumed", exp_q.size(), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t5_no_trailing_beats", beats - base, 0);
        check("t5_in_ready_after", {31'h0, in_ready}, 32'h1);
        check("t5_valid_after", {31'h0, out_valid}, 32'h0);

        // 6: in_valid held with out_ready low for 10 cycles
        out_ready = 1'b0;
        in_valid = 1'b1;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            v = 32'hC3C2C1C0 + i;
            parallel_in = v;
            if (in_ready) begin
                accepts++;
                push_word(v);
            end
            tick();
        end
        in_valid = 1'b0;
        check("t6_accepts", accepts, 2);
        check("t6_in_ready_low", {31'h0, in_ready}, 32'h0);
        check("t6_valid_held", {31'h0, out_valid}, 32'h1);
        check("t6_beat0_held", {24'h0, out_serial}, 32'hC0);
        check("t6_first_held", {31'h0, out_first}, 32'h1);
        have_prev = 1'b0;
        contig_chk = 1'b1;
        out_ready = 1'b1;
        drain(20);
        contig_chk = 1'b0;
        tick();
        check("t6_idle_valid", {31'h0, out_valid}, 32'h0);
        check("t6_idle_busy", {31'h0, busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
